ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master_pkg.sv | 32 +++
 rtl/ahb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_ahb_cmd_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cmd_master_pkg.sv
// Shared AHB encodings, FSM state and captured-command bundle
// for the single-transfer AHB-Lite command master.
package ahb_cmd_master_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HS_BYTE = 3'b000,
    HS_HALF = 3'b001,
    HS_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ahb_cmd_master.sv
// Command-to-AHB-Lite master, one transfer in flight.
// AHB_CMD_MASTER_TIMEOUT_EN adds a data-phase timeout and timeout_o.
module ahb_cmd_master
  import ahb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  output logic        timeout_o,
`endif
  input  logic        HRESP
);

  state_t      state_q, state_d;
  cmd_t        cmd_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        up_q;
  logic        cmd_take;
  logic        rsp_take;
  logic        tmo_hit;
  logic        tmo_reach;
  logic        tmo_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cmd_take = 1'b0;
    rsp_take = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = ST_ADDR;
          cmd_take = 1'b1;
        end
      end
      ST_ADDR: begin
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d  = ST_RESP;
          rsp_take = 1'b1;
        end else if (tmo_reach) begin
          state_d = ST_RESP;
          tmo_hit = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // up_q keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cmd_q   <= '{write: 1'b0, addr: '0,
                   size: HS_WORD, wdata: '0};
      rdata_q <= '0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (cmd_take) begin
        cmd_q <= '{write: cmd_write, addr: cmd_addr,
                   size: cmd_size, wdata: cmd_wdata};
      end
      if (rsp_take) begin
        rdata_q <= cmd_q.write ? '0 : HRDATA;
        err_q   <= HRESP;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q != ST_DATA || HREADY) tcnt_q <= '0;
      else                              tcnt_q <= tcnt_q + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign tmo_reach = (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = tmo_q;
`else
  logic unused_cfg;

  assign unused_cfg = TIMEOUT_CYCLES[0];
  assign tmo_reach  = 1'b0;
  assign tmo_q      = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && up_q && !tmo_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign HTRANS = (state_q == ST_ADDR) ? HT_NONSEQ : HT_IDLE;
  assign HADDR  = cmd_q.addr;
  assign HWRITE = cmd_q.write;
  assign HSIZE  = cmd_q.size;
  assign HWDATA = (state_q == ST_DATA && cmd_q.write) ?
                  cmd_q.wdata : '0;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Randomized bench for ahb_cmd_master; the bench plays the AHB slave
// and predicts every phase from the transfer's timing rules.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  logic        timeout_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  ahb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY),
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, ".haddr"}, HADDR, 32'h0);
    chk({tag, ".hwrite"}, 32'(HWRITE), 32'h0);
    chk({tag, ".hsize"}, 32'(HSIZE), 32'h2);
    chk({tag, ".hwdata"}, HWDATA, 32'h0);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'h0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'h0);
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    chk({tag, ".timeout"}, 32'(timeout_o), 32'h0);
`endif
  endtask

  // One full transfer: aw/dw are slave wait states in the address and
  // data phases, err ends the data phase with a two-cycle ERROR,
  // rdly is how many cycles the response is left unaccepted.
  task automatic txn(input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wd,
                     input logic [31:0] rd, input int aw,
                     input int dw, input logic err, input int rdly);
    logic [31:0] exp_rd;
    exp_rd = wr ? 32'h0 : rd;
    @(negedge HCLK);
    chk("idle.cmd_ready", 32'(cmd_ready), 32'h1);
    chk("idle.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle.htrans", 32'(HTRANS), 32'h0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
    HREADY    = 1'($urandom);
    HRESP     = 1'b0;
    for (int i = 0; i <= aw; i++) begin
      @(negedge HCLK);
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      chk("addr.htrans", 32'(HTRANS), 32'h2);
      chk("addr.haddr", HADDR, addr);
      chk("addr.hwrite", 32'(HWRITE), 32'(wr));
      chk("addr.hsize", 32'(HSIZE), 32'(size));
      chk("addr.cmd_ready", 32'(cmd_ready), 32'h0);
      chk("addr.rsp_valid", 32'(rsp_valid), 32'h0);
      HREADY = (i == aw);
    end
    for (int j = 0; j <= dw; j++) begin
      @(negedge HCLK);
      chk("data.htrans", 32'(HTRANS), 32'h0);
      chk("data.hwdata", HWDATA, wr ? wd : 32'h0);
      chk("data.rsp_valid", 32'(rsp_valid), 32'h0);
      HREADY = (j == dw);
      HRESP  = err && (j >= dw - 1);
      HRDATA = (j == dw) ? rd : $urandom;
    end
    for (int k = 0; k <= rdly; k++) begin
      @(negedge HCLK);
      HREADY = 1'($urandom);
      HRESP  = 1'b0;
      HRDATA = $urandom;
      chk("rsp.valid", 32'(rsp_valid), 32'h1);
      chk("rsp.rdata", rsp_rdata, exp_rd);
      chk("rsp.err", 32'(rsp_err), 32'(err));
      chk("rsp.cmd_ready", 32'(cmd_ready), 32'h0);
      chk("rsp.htrans", 32'(HTRANS), 32'h0);
      rsp_ready = (k == rdly);
    end
    @(negedge HCLK);
    rsp_ready = 1'b0;
    chk("done.rsp_valid", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    HRDATA    = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;

    repeat (2) @(negedge HCLK);
    chk_reset_vals("por");
    HRESETn = 1'b1;
    #1;
    chk("rel.cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge HCLK);
    chk("rel1.cmd_ready", 32'(cmd_ready), 32'h1);

    txn(1'b1, 32'h20, 3'b010, 32'h0000_0ABC, 32'h0, 0, 0, 1'b0, 0);
    txn(1'b0, 32'h20, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b0, 0);
    txn(1'b0, 32'h24, 3'b010, 32'h0, 32'h1234_5678, 0, 1, 1'b1, 0);
    txn(1'b0, 32'h28, 3'b001, 32'h0, 32'hCAFE_F00D, 1, 0, 1'b0, 4);

    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h40;
    cmd_size  = 3'b010;
    cmd_wdata = 32'h5555_AAAA;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    HREADY    = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    chk("mid.hwdata", HWDATA, 32'h5555_AAAA);
    #2 HRESETn = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge HCLK);
    HRESETn   = 1'b1;
    HREADY    = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge HCLK);
      chk("post.rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post.htrans", 32'(HTRANS), 32'h0);
    end
    rsp_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), $urandom, 3'($urandom),
          $urandom, $urandom,
          int'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 2)));
    end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h80;
    HREADY    = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    HREADY    = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge HCLK);
      HREADY = 1'b0;
      HRDATA = 32'hFFFF_0000 | 32'(j);
      chk("tmo.wait.valid", 32'(rsp_valid), 32'h0);
      chk("tmo.wait.flag", 32'(timeout_o), 32'h0);
    end
    @(negedge HCLK);
    chk("tmo.valid", 32'(rsp_valid), 32'h1);
    chk("tmo.err", 32'(rsp_err), 32'h1);
    chk("tmo.rdata", rsp_rdata, 32'h0);
    chk("tmo.flag", 32'(timeout_o), 32'h1);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      chk("tmo.cmd_ready", 32'(cmd_ready), 32'h0);
      chk("tmo.sticky", 32'(timeout_o), 32'h1);
      chk("tmo.htrans", 32'(HTRANS), 32'h0);
    end
    cmd_valid = 1'b0;
    HRESETn   = 1'b0;
    #1;
    chk_reset_vals("tmo.rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    @(negedge HCLK);
    chk("tmo.rel.cmd_ready", 32'(cmd_ready), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
